// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - Avalon-MM requester bus between an interconnect master and the RAM arbiter
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master round-robin arbiter with burst hold for one single-port RAM (optional ARB_RANGE_CHECK_EN)
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32000,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                reset,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                range_err
);

  localparam int         BE_W      = DATA_W / 8;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] OWN0      = 2'd1;
  localparam logic [1:0] OWN1      = 2'd2;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  logic [1:0] state, state_nxt;
  logic [7:0] burst_cnt, burst_nxt, burst_sat;
  logic       last_grant;   // 1 = m1 was the most recent owner
  logic       clken_q;
  logic       req0, req1, gnt0, gnt1, gnt_any;
  logic       cmd_write, in_range;
  logic       rd_tag0, rd_tag1, oor_tag;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign gnt_any = gnt0 | gnt1;

  // Grant decision: owner keeps the RAM until its burst is used up while the other waits
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // No grants until the RAM clock enable is up, so nothing is issued into a gated RAM
    if (clken_q) begin
      case (state)
        OWN0: begin
          if (req0 && (!req1 || burst_cnt < BURST_MAX)) gnt0 = 1'b1;
          else if (req1)                                gnt1 = 1'b1;
        end
        OWN1: begin
          if (req1 && (!req0 || burst_cnt < BURST_MAX)) gnt1 = 1'b1;
          else if (req0)                                gnt0 = 1'b1;
        end
        default: begin
          if (req0 && (!req1 || last_grant)) gnt0 = 1'b1;
          else if (req1)                     gnt1 = 1'b1;
        end
      endcase
    end
  end

  assign burst_sat = (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 8'd1;

  // Next owner and burst length; a change of owner restarts the count at 1
  always_comb begin
    state_nxt = IDLE;
    burst_nxt = 8'd0;
    if (gnt0) begin
      state_nxt = OWN0;
      burst_nxt = (state == OWN0) ? burst_sat : 8'd1;
    end else if (gnt1) begin
      state_nxt = OWN1;
      burst_nxt = (state == OWN1) ? burst_sat : 8'd1;
    end
  end

  // RAM command is the winner's command, presented in the grant cycle itself
  assign cmd_write      = gnt1 ? m1.write : m0.write;
  assign mem_address    = gnt1 ? m1.address : m0.address;
  assign mem_writedata  = gnt1 ? m1.writedata : m0.writedata;
  assign mem_byteenable = cmd_write ? (gnt1 ? m1.byteenable : m0.byteenable) : {BE_W{1'b1}};
  assign mem_chipselect = gnt_any & in_range;
  assign mem_write      = gnt_any & cmd_write & in_range;
  assign mem_clken      = clken_q;

`ifdef ARB_RANGE_CHECK_EN
  assign in_range  = ({{(32-ADDR_W){1'b0}}, mem_address} < 32'(DEPTH));
  assign range_err = gnt_any & ~in_range;
`else
  assign in_range  = 1'b1;
  assign range_err = 1'b0;
`endif

  assign m0.waitrequest = ~gnt0;
  assign m1.waitrequest = ~gnt1;

  // The RAM q register is the data pipeline stage; only the owner tag is registered here
  assign m0.readdatavalid = rd_tag0;
  assign m1.readdatavalid = rd_tag1;
  assign m0.readdata      = (rd_tag0 && !oor_tag) ? mem_readdata : '0;
  assign m1.readdata      = (rd_tag1 && !oor_tag) ? mem_readdata : '0;

  // Arbitration state, burst counter, fairness memory and RAM clock enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= 8'd0;
      last_grant <= 1'b1;
      clken_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      clken_q   <= 1'b1;
      if (gnt_any) last_grant <= gnt1;
    end
  end

  // Read return tags: which master the RAM output belongs to next cycle (write wins over read)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_tag0 <= 1'b0;
      rd_tag1 <= 1'b0;
      oor_tag <= 1'b0;
    end else begin
      rd_tag0 <= gnt0 & ~m0.write;
      rd_tag1 <= gnt1 & ~m1.write;
      oor_tag <= ~in_range;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - scoreboard bench for onchip_mem_arbiter with a behavioural arbitration and memory model
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 32000;
  localparam int MAX_BURST = 8;
`ifdef ARB_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus();

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken, range_err;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata = 32'h0;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .range_err(range_err)
  );

  // Environment RAM: single port, one-cycle read latency
  logic [31:0] ram [0:32767] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [0:32767] = '{default: 32'h0};
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int own = -1;
  int run = 0;
  int lastg = 1;
  bit armed = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    armed = !reset;
  end

  // Arbitration/memory model: predicts the winner each cycle and queues expected read data
  initial begin
    int g;
    bit r0, r1, oor, wr;
    logic [14:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    forever begin
      @(negedge clk);
      if (reset) begin
        own = -1; run = 0; lastg = 1;
        exp0.delete(); exp1.delete();
      end else begin
        r0 = m0_bus.read | m0_bus.write;
        r1 = m1_bus.read | m1_bus.write;
        g = -1;
        if (armed) begin
          if (r0 && r1)  g = (own < 0) ? 1 - lastg : ((run < MAX_BURST) ? own : 1 - own);
          else if (r0)   g = 0;
          else if (r1)   g = 1;
        end
        check(m0_bus.waitrequest == (g != 0), "m0_waitrequest", 32'(m0_bus.waitrequest), 32'(g != 0));
        check(m1_bus.waitrequest == (g != 1), "m1_waitrequest", 32'(m1_bus.waitrequest), 32'(g != 1));
        check(mem_clken == armed, "mem_clken", 32'(mem_clken), 32'(armed));
        a = 15'h0; wr = 1'b0; wd = 32'h0; be = 4'h0; oor = 1'b0;
        if (g >= 0) begin
          a  = (g == 1) ? m1_bus.address : m0_bus.address;
          wr = (g == 1) ? m1_bus.write : m0_bus.write;
          wd = (g == 1) ? m1_bus.writedata : m0_bus.writedata;
          be = (g == 1) ? m1_bus.byteenable : m0_bus.byteenable;
          oor = RANGE_EN && (int'(a) >= DEPTH);
        end
        check(range_err == oor, "range_err", 32'(range_err), 32'(oor));
        check(mem_chipselect == (g >= 0 && !oor), "mem_chipselect", 32'(mem_chipselect), 32'(g >= 0 && !oor));
        if (g >= 0) begin
          check(mem_address == a, "mem_address", 32'(mem_address), 32'(a));
          if (wr) begin
            if (!oor)
              for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
          end else if (g == 0) begin
            exp0.push_back(oor ? 32'h0 : ref_mem[a]);
          end else begin
            exp1.push_back(oor ? 32'h0 : ref_mem[a]);
          end
          run = (g == own) ? ((run < MAX_BURST) ? run + 1 : MAX_BURST) : 1;
          own = g;
          lastg = g;
        end else begin
          own = -1;
        end
      end
    end
  end

  // Read-return monitor: pops the scoreboard whenever a readdatavalid pulse appears
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m0_bus.readdatavalid) begin
          check(exp0.size() != 0, "m0_unexpected_rdv", m0_bus.readdata, 32'h0);
          if (exp0.size() != 0) begin
            e = exp0.pop_front();
            check(m0_bus.readdata === e, "m0_readdata", m0_bus.readdata, e);
          end
        end
        if (m1_bus.readdatavalid) begin
          check(exp1.size() != 0, "m1_unexpected_rdv", m1_bus.readdata, 32'h0);
          if (exp1.size() != 0) begin
            e = exp1.pop_front();
            check(m1_bus.readdata === e, "m1_readdata", m1_bus.readdata, e);
          end
        end
      end
    end
  end

  task automatic set_cmd(input int m, input logic rd, input logic wr, input logic [14:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a; m0_bus.writedata = d; m0_bus.byteenable = be;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a; m1_bus.writedata = d; m1_bus.byteenable = be;
    end
  endtask

  function automatic logic wreq(input int m);
    return (m == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
  endfunction

  function automatic logic reqn(input int m);
    return (m == 0) ? (m0_bus.read | m0_bus.write) : (m1_bus.read | m1_bus.write);
  endfunction

  // Issue one command (called just after a rising edge) and hold it until accepted
  task automatic do_op(input int m, input logic rd, input logic wr, input logic [14:0] a,
                       input logic [31:0] d, input logic [3:0] be, output int waits);
    set_cmd(m, rd, wr, a, d, be);
    waits = 0;
    @(negedge clk);
    while (wreq(m) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check(waits < 20, "accept_timeout", 32'(waits), 32'd20);
    @(posedge clk); #1;
    set_cmd(m, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
  endtask

  task automatic rand_cmd(input int m);
    int op;
    logic [14:0] a;
    op = $urandom_range(0, 3);
    a = ($urandom_range(0, 9) == 0) ? 15'(DEPTH + $urandom_range(0, 5)) : 15'($urandom_range(0, 63));
    set_cmd(m, op == 1 || op == 3, op >= 2, a, $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    int waits, g;
    bit a0, a1;

    set_cmd(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(m0_bus.waitrequest === 1'b1 && m1_bus.waitrequest === 1'b1, "reset_waitrequest",
          {30'h0, m1_bus.waitrequest, m0_bus.waitrequest}, 32'h3);
    check(m0_bus.readdatavalid === 1'b0 && m1_bus.readdatavalid === 1'b0, "reset_rdv",
          {30'h0, m1_bus.readdatavalid, m0_bus.readdatavalid}, 32'h0);
    check(mem_clken === 1'b0 && mem_chipselect === 1'b0 && mem_write === 1'b0 && range_err === 1'b0,
          "reset_mem_ctrl", {28'h0, mem_clken, mem_chipselect, mem_write, range_err}, 32'h0);

    // Both masters requesting from the first cycle after reset: 8 grants each, alternating
    set_cmd(0, 1'b1, 1'b0, 15'h4, 32'h0, 4'hF);
    set_cmd(1, 1'b1, 1'b0, 15'h5, 32'h0, 4'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      g = !m0_bus.waitrequest ? 0 : (!m1_bus.waitrequest ? 1 : 2);
      check(g == ((i < 8 || i >= 16) ? 0 : 1), "burst_sequence", 32'(g), 32'((i < 8 || i >= 16) ? 0 : 1));
    end
    @(posedge clk); #1;
    set_cmd(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

    // m0 write then read back with zero wait states
    do_op(0, 1'b0, 1'b1, 15'h0010, 32'hA5A5_1234, 4'hF, waits);
    check(waits == 0, "m0_write_waits", 32'(waits), 32'd0);
    do_op(0, 1'b1, 1'b0, 15'h0010, 32'h0, 4'hF, waits);
    check(waits == 0, "m0_read_waits", 32'(waits), 32'd0);
    @(negedge clk);
    check(m0_bus.readdatavalid === 1'b1 && m0_bus.readdata === 32'hA5A5_1234, "m0_readback",
          m0_bus.readdata, 32'hA5A5_1234);

    // Byte-lane merge from m1, read back through m0
    @(posedge clk); #1;
    do_op(1, 1'b0, 1'b1, 15'h0020, 32'hFFFF_FFFF, 4'hF, waits);
    do_op(1, 1'b0, 1'b1, 15'h0020, 32'h0000_00AB, 4'b0001, waits);
    do_op(0, 1'b1, 1'b0, 15'h0020, 32'h0, 4'hF, waits);
    @(negedge clk);
    check(m0_bus.readdatavalid === 1'b1 && m0_bus.readdata === 32'hFFFF_FFAB, "byte_merge",
          m0_bus.readdata, 32'hFFFF_FFAB);

    // Back-to-back reads alternating masters route data to the right requester
    @(posedge clk); #1;
    do_op(0, 1'b0, 1'b1, 15'd1, 32'd1, 4'hF, waits);
    do_op(1, 1'b0, 1'b1, 15'd2, 32'd2, 4'hF, waits);
    do_op(0, 1'b0, 1'b1, 15'd3, 32'd3, 4'hF, waits);
    set_cmd(0, 1'b1, 1'b0, 15'd1, 32'h0, 4'hF);
    @(posedge clk); #1;
    set_cmd(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b1, 1'b0, 15'd2, 32'h0, 4'hF);
    @(negedge clk);
    check(m0_bus.readdatavalid === 1'b1 && m0_bus.readdata === 32'd1 && m1_bus.readdatavalid === 1'b0,
          "b2b_first", m0_bus.readdata, 32'd1);
    @(posedge clk); #1;
    set_cmd(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    set_cmd(0, 1'b1, 1'b0, 15'd3, 32'h0, 4'hF);
    @(negedge clk);
    check(m1_bus.readdatavalid === 1'b1 && m1_bus.readdata === 32'd2 && m0_bus.readdatavalid === 1'b0,
          "b2b_second", m1_bus.readdata, 32'd2);
    @(posedge clk); #1;
    set_cmd(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    @(negedge clk);
    check(m0_bus.readdatavalid === 1'b1 && m0_bus.readdata === 32'd3, "b2b_third", m0_bus.readdata, 32'd3);

    // Out-of-range read: blocked and zeroed with the check enabled, forwarded without it
    @(posedge clk); #1;
    set_cmd(0, 1'b1, 1'b0, 15'd32000, 32'h0, 4'hF);
    @(negedge clk);
    check(m0_bus.waitrequest === 1'b0, "oor_accept", 32'(m0_bus.waitrequest), 32'd0);
    check(range_err === RANGE_EN, "oor_range_err", 32'(range_err), 32'(RANGE_EN));
    check(mem_chipselect === !RANGE_EN, "oor_chipselect", 32'(mem_chipselect), 32'(!RANGE_EN));
    @(posedge clk); #1;
    set_cmd(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    @(negedge clk);
    check(m0_bus.readdatavalid === 1'b1 && m0_bus.readdata === 32'h0, "oor_readdata", m0_bus.readdata, 32'h0);

    // Reset the cycle after an m1 read accept: the in-flight return is discarded
    @(posedge clk); #1;
    set_cmd(1, 1'b1, 1'b0, 15'd2, 32'h0, 4'hF);
    @(negedge clk);
    check(m1_bus.waitrequest === 1'b0, "pre_reset_accept", 32'(m1_bus.waitrequest), 32'd0);
    @(posedge clk); #1;
    set_cmd(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    reset = 1'b1;
    @(negedge clk);
    check(m1_bus.readdatavalid === 1'b0 && m1_bus.readdata === 32'h0, "reset_discard_rdv",
          {31'h0, m1_bus.readdatavalid}, 32'h0);
    check(mem_clken === 1'b0 && mem_chipselect === 1'b0 && range_err === 1'b0, "reset_mid_outputs",
          {29'h0, mem_clken, mem_chipselect, range_err}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check(mem_clken === 1'b0, "clken_before_edge", 32'(mem_clken), 32'd0);
    @(posedge clk); #1;
    check(mem_clken === 1'b1, "clken_after_edge", 32'(mem_clken), 32'd1);

    // Randomized traffic from both masters, holding each command until accepted
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a0 = reqn(0) && !m0_bus.waitrequest;
      a1 = reqn(1) && !m1_bus.waitrequest;
      @(posedge clk); #1;
      if (a0 || !reqn(0)) rand_cmd(0);
      if (a1 || !reqn(1)) rand_cmd(1);
    end
    // Let any held command finish, then drain
    for (int c = 0; c < 40 && (reqn(0) || reqn(1)); c++) begin
      @(negedge clk);
      a0 = reqn(0) && !m0_bus.waitrequest;
      a1 = reqn(1) && !m1_bus.waitrequest;
      @(posedge clk); #1;
      if (a0) set_cmd(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
      if (a1) set_cmd(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    end
    set_cmd(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(exp0.size() == 0 && exp1.size() == 0, "scoreboard_drained",
          32'(exp0.size() + exp1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
